dmem_responder: RTL

//   Data-memory responder for the pipeline CPU's MEM-stage port (mem_w/Addr/Data). Serves same-cycle

---
 rtl/dmem_responder_pkg.sv | 12 +
 rtl/dmem_responder_if.sv | 8 +
 rtl/dmem_store_buffer.sv | 56 +++++
 rtl/dmem_responder.sv | 69 ++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg: DMType codes, access sizes and the store-buffer write record
package dmem_responder_pkg;
  localparam logic [2:0] DM_WORD = 3'd0, DM_HALF = 3'd1, DM_HALF_U = 3'd2, DM_BYTE = 3'd3, DM_BYTE_U = 3'd4;
  typedef enum logic [1:0] {SZ_WORD, SZ_HALF, SZ_BYTE} size_e;
  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  mask;
  } sb_wr_t;
  function automatic size_e dm_size(input logic [2:0] dm);
    return (dm == DM_HALF || dm == DM_HALF_U) ? SZ_HALF : (dm == DM_BYTE || dm == DM_BYTE_U) ? SZ_BYTE : SZ_WORD;
  endfunction
endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: CPU MEM-stage data port (requests from master, load data/stall/fault from slave)
interface dmem_responder_if;
  logic        mem_w, mem_r, stall, fault;
  logic [31:0] Addr_in, Data_in, Data_out;
  logic [2:0]  DMType;
  modport master (output mem_w, mem_r, Addr_in, Data_in, DMType, input Data_out, stall, fault);
  modport slave (input mem_w, mem_r, Addr_in, Data_in, DMType, output Data_out, stall, fault);
endinterface

// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer: circular store FIFO with oldest-to-youngest byte forwarding for one queried word
module dmem_store_buffer
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int SB_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enq,
  input  logic              deq,
  input  logic [ADDR_W-1:0] enq_idx,
  input  sb_wr_t            enq_wr,
  input  logic [ADDR_W-1:0] q_idx,
  input  logic [31:0]       q_base,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W-1:0] hd_idx,
  output sb_wr_t            hd_wr,
  output logic [31:0]       q_data
);
  localparam int PW = $clog2(SB_DEPTH);
  logic [ADDR_W-1:0] idx [SB_DEPTH];
  sb_wr_t            wr  [SB_DEPTH];
  logic [PW-1:0]     head, tail, p;
  logic [PW:0]       count;
  assign full   = count == (PW+1)'(SB_DEPTH);
  assign empty  = count == '0;
  assign hd_idx = idx[head];
  assign hd_wr  = wr[head];
  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) begin
        idx[tail] <= enq_idx;
        wr[tail]  <= enq_wr;
        tail      <= tail + 1'b1;
      end
      if (deq) head <= head + 1'b1;
      count <= count + (PW+1)'(enq) - (PW+1)'(deq);
    end
  end
  // Walk from head so younger entries overwrite older ones lane by lane
  always_comb begin
    q_data = q_base;
    p = head;
    for (int i = 0; i < SB_DEPTH; i++) begin
      for (int b = 0; b < 4; b++)
        if (i < int'(count) && idx[p] == q_idx && wr[p].mask[b]) q_data[8*b +: 8] = wr[p].data[8*b +: 8];
      p = p + 1'b1;
    end
  end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: MEM-stage data memory with buffered stores, loader port and DMType sizing.
// Define DMEM_ALIGN_CHECK_EN to reject misaligned half/word accesses with a registered fault pulse.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int SB_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  dmem_responder_if.slave   bus,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_data
);
  logic [31:0]       ram [2**ADDR_W];
  logic [ADDR_W-1:0] idx, hd_idx;
  logic [1:0]        off;
  logic [3:0]        mask;
  logic [31:0]       wdata, merged, lane;
  logic              mis, full, empty, enq, deq, unused_hi;
  size_e             sz;
  sb_wr_t            hd_wr;
  assign sz        = dm_size(bus.DMType);
  assign idx       = bus.Addr_in[ADDR_W+1:2];
  assign unused_hi = ^bus.Addr_in[31:ADDR_W+2];
`ifdef DMEM_ALIGN_CHECK_EN
  assign mis = (bus.mem_w | bus.mem_r) & (sz == SZ_WORD ? |bus.Addr_in[1:0] : (sz == SZ_HALF) & bus.Addr_in[0]);
  assign off = bus.Addr_in[1:0];
  always_ff @(posedge clk) bus.fault <= reset ? 1'b0 : mis;
`else
  assign mis       = 1'b0;
  assign off       = sz == SZ_WORD ? 2'd0 : sz == SZ_HALF ? {bus.Addr_in[1], 1'b0} : bus.Addr_in[1:0];
  assign bus.fault = 1'b0;
`endif
  // Replicated lanes let the mask alone pick the right bytes on drain and forward
  assign mask      = sz == SZ_WORD ? 4'hf : (sz == SZ_HALF ? 4'b0011 : 4'b0001) << off;
  assign wdata     = sz == SZ_WORD ? bus.Data_in : sz == SZ_HALF ? {2{bus.Data_in[15:0]}} : {4{bus.Data_in[7:0]}};
  assign bus.stall = bus.mem_w & full & ld_we;
  assign enq       = bus.mem_w & ~bus.stall & ~mis;
  assign deq       = ~empty & ~ld_we & ~reset;
  dmem_store_buffer #(.ADDR_W(ADDR_W), .SB_DEPTH(SB_DEPTH)) u_sb (
    .clk    (clk),
    .reset  (reset),
    .enq    (enq),
    .deq    (deq),
    .enq_idx(idx),
    .enq_wr ('{data: wdata, mask: mask}),
    .q_idx  (idx),
    .q_base (ram[idx]),
    .full   (full),
    .empty  (empty),
    .hd_idx (hd_idx),
    .hd_wr  (hd_wr),
    .q_data (merged)
  );
  // Loader owns the write port; the drain simply waits a cycle
  always_ff @(posedge clk) begin
    if (ld_we) ram[ld_addr] <= ld_data;
    else if (deq)
      for (int b = 0; b < 4; b++) if (hd_wr.mask[b]) ram[hd_idx][8*b +: 8] <= hd_wr.data[8*b +: 8];
  end
  assign lane = merged >> {off, 3'b000};
  assign bus.Data_out = (~bus.mem_r | mis) ? 32'd0 :
                        bus.DMType == DM_HALF   ? {{16{lane[15]}}, lane[15:0]} :
                        bus.DMType == DM_HALF_U ? {16'd0, lane[15:0]} :
                        bus.DMType == DM_BYTE   ? {{24{lane[7]}}, lane[7:0]} :
                        bus.DMType == DM_BYTE_U ? {24'd0, lane[7:0]} : lane;
endmodule
